// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the MIMO-OFDM datapath (multiplier
// and dot-product accumulator). The struct and constants describe the default
// single-precision layout; parameterised modules use the helper functions
// for their own widths.
package fp_pkg;

  localparam int FP_EXP = 8;
  localparam int FP_MNT = 23;

  // Exponent bias of the default format.
  localparam int EXP_BASE = (1 << (FP_EXP - 1)) - 1;

  // Largest finite magnitude: exponent all-ones minus one, mantissa all ones.
  localparam logic [FP_EXP-1:0] SAT_EXP = FP_EXP'((1 << FP_EXP) - 2);
  localparam logic [FP_MNT-1:0] SAT_MNT = '1;

  typedef struct packed {
    logic              sign;
    logic [FP_EXP-1:0] exp;
    logic [FP_MNT-1:0] mant;
  } fp_t;

  // Zero-exponent operands (zeros and denormals) are treated as +0.
  // The exponent field is passed zero-extended so any width up to 32 works.
  function automatic logic is_zero(input logic [31:0] exp_field);
    return exp_field == '0;
  endfunction

endpackage

// File: rtl/fp_add_core.sv
// Combinational floating-point adder, truncating, no NaN/Inf.
//   a, b : operand words {sign, exp, mant}
//   sum  : a + b; zero-exponent inputs flush to +0, exact zero encodes as +0,
//          exponent underflow flushes to +0, overflow saturates to the
//          largest finite value of the result sign.
module fp_add_core
  import fp_pkg::*;
#(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = I_EXP + I_MNT + 1
) (
  input  logic [I_DATA-1:0] a,
  input  logic [I_DATA-1:0] b,
  output logic [I_DATA-1:0] sum
);

  localparam int W  = I_MNT + 3;  // hidden bit + mantissa + 2 guard bits
  localparam int EW = I_EXP + 2;  // signed working exponent with headroom
  localparam logic signed [EW-1:0] E_OVF = EW'((1 << I_EXP) - 1);
  localparam logic [I_EXP-1:0]     S_EXP = I_EXP'((1 << I_EXP) - 2);

  logic [I_DATA-1:0] fa, fb, big, sml;
  logic              swap;
  logic [I_EXP-1:0]  diff;
  logic [W-1:0]      mb, ms, ms_al, dif_w, norm;
  logic [W:0]        sum_w;
  logic signed [EW-1:0] e;
  int                lz;
  logic              unused_guard;

  assign fa = is_zero(32'(a[I_DATA-2:I_MNT])) ? '0 : a;
  assign fb = is_zero(32'(b[I_DATA-2:I_MNT])) ? '0 : b;

  // Magnitude order on {exp, mant}; ties need no special case.
  assign swap = fb[I_DATA-2:0] > fa[I_DATA-2:0];
  assign big  = swap ? fb : fa;
  assign sml  = swap ? fa : fb;

  // Hidden bit is only present for non-flushed operands.
  assign mb = {|big[I_DATA-2:I_MNT], big[I_MNT-1:0], 2'b00};
  assign ms = {|sml[I_DATA-2:I_MNT], sml[I_MNT-1:0], 2'b00};

  assign diff  = big[I_DATA-2:I_MNT] - sml[I_DATA-2:I_MNT];
  assign ms_al = (32'(diff) >= I_MNT + 3) ? '0 : (ms >> diff);

  assign sum_w = {1'b0, mb} + {1'b0, ms_al};
  assign dif_w = mb - ms_al;

  always_comb begin
    lz   = W;
    norm = '0;
    e    = EW'(big[I_DATA-2:I_MNT]);
    if (big[I_DATA-1] == sml[I_DATA-1]) begin
      if (sum_w[W]) begin
        norm = sum_w[W:1];
        e    = e + EW'(1);
      end else begin
        norm = sum_w[W-1:0];
      end
    end else begin
      // Leading-one detect: the highest set bit wins as i climbs.
      for (int i = 0; i < W; i++) begin
        if (dif_w[i]) lz = W - 1 - i;
      end
      norm = dif_w << lz;
      e    = e - EW'(lz);
    end
  end

  assign unused_guard = ^norm[1:0];

  always_comb begin
    if (!norm[W-1] || e[EW-1] || e == '0)
      sum = '0;
    else if (e >= E_OVF)
      sum = {big[I_DATA-1], S_EXP, {I_MNT{1'b1}}};
    else
      sum = {big[I_DATA-1], e[I_EXP-1:0], norm[W-2:2]};
  end

endmodule

// File: rtl/fp_dot_acc.sv
// Dot-product accumulator downstream of the FP multiplier. Sums runs of
// VEC_LEN accepted products and publishes one result per run.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : in_data holds a product this cycle (no backpressure)
//   in_data    : product word {sign, exp, mant}
//   odata      : last completed sum, held until the next completion
//   out_valid  : one-cycle pulse when odata updates
//   elem_cnt   : elements accepted so far in the current run
module fp_dot_acc
  import fp_pkg::*;
#(
  parameter int I_EXP   = 8,
  parameter int I_MNT   = 23,
  parameter int I_DATA  = I_EXP + I_MNT + 1,
  parameter int VEC_LEN = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [I_DATA-1:0]          in_data,
  output logic [I_DATA-1:0]          odata,
  output logic                       out_valid,
  output logic [$clog2(VEC_LEN)-1:0] elem_cnt
);

  localparam int            CW   = $clog2(VEC_LEN);
  localparam logic [CW-1:0] LAST = CW'(VEC_LEN - 1);

  logic [I_DATA-1:0] acc, add_res, in_norm;

  fp_add_core #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (add_res)
  );

  // First element of a run is loaded as-is, apart from zero flushing.
  assign in_norm = is_zero(32'(in_data[I_DATA-2:I_MNT])) ? '0 : in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= '0;
      odata     <= '0;
      out_valid <= 1'b0;
      elem_cnt  <= '0;
    end else begin
      out_valid <= in_valid && (elem_cnt == LAST);
      if (in_valid) begin
        if (elem_cnt == LAST) begin
          // Completion consumes this element; acc is reloaded by the next run.
          odata    <= add_res;
          elem_cnt <= '0;
        end else begin
          acc      <= (elem_cnt == '0) ? in_norm : add_res;
          elem_cnt <= elem_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_dot_acc.sv
module tb_fp_dot_acc;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] odata;
  logic        out_valid;
  logic [1:0]  elem_cnt;

  int nchk = 0;
  int nerr = 0;
  int pulses = 0;

  fp_dot_acc #(.I_EXP(8), .I_MNT(23), .VEC_LEN(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .odata     (odata),
    .out_valid (out_valid),
    .elem_cnt  (elem_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) pulses++;

  typedef struct {
    logic [31:0] v [4];
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic run(input logic [31:0] v [4], input int gap, input logic [31:0] req, input string name);
    for (int i = 0; i < 4; i++) begin
      push(v[i]);
      chk({name, " cnt"}, 32'(elem_cnt), 32'((i + 1) % 4));
      if (i < 3) begin
        chk({name, " early_vld"}, 32'(out_valid), 32'(0));
        idle(gap);
      end else begin
        chk({name, " vld"}, 32'(out_valid), 32'(1));
        chk({name, " odata"}, odata, req);
      end
    end
    idle(1);
    chk({name, " vld_drop"}, 32'(out_valid), 32'(0));
    chk({name, " hold"}, odata, req);
  endtask

  // Reference adder: sign-magnitude integers scaled to the larger operand,
  // with the smaller term truncated to two bits below the larger's LSB.
  function automatic logic [31:0] m_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    longint hb, hs, r, m;
    int eb, es, d, p, e;
    if (x[30:23] == 0) x = 0;
    if (y[30:23] == 0) y = 0;
    if (y[30:0] > x[30:0]) begin t = x; x = y; y = t; end
    eb = int'(x[30:23]);
    es = int'(y[30:23]);
    hb = (eb == 0) ? 0 : (longint'({1'b1, x[22:0]}) * 4);
    hs = (es == 0) ? 0 : (longint'({1'b1, y[22:0]}) * 4);
    d  = eb - es;
    hs = (d >= 26) ? 0 : (hs >> d);
    r  = (x[31] == y[31]) ? hb + hs : hb - hs;
    if (r <= 0) return 32'h0;
    p = 0;
    while ((r >> (p + 1)) != 0) p++;
    e = eb + p - 25;
    m = (p >= 23) ? (r >> (p - 23)) : (r << (23 - p));
    if (e <= 0) return 32'h0;
    if (e >= 255) return {x[31], 8'hFE, 23'h7FFFFF};
    return {x[31], e[7:0], m[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    int sel = $urandom_range(0, 9);
    if (sel == 0)      e = 8'd0;
    else if (sel == 1) e = 8'($urandom_range(250, 254));
    else               e = 8'($urandom_range(120, 135));
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  vec_t tbl [7];
  logic [31:0] rv [4];
  logic [31:0] racc;
  int p0;

  initial begin
    tbl[0] = '{v: '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000}, exp: 32'h41200000};
    tbl[1] = '{v: '{32'h3FC00000, 32'hBFC00000, 32'h00000000, 32'h3E800000}, exp: 32'h3E800000};
    tbl[2] = '{v: '{32'h3FC00000, 32'hBFC00000, 32'h00000000, 32'h00000000}, exp: 32'h00000000};
    tbl[3] = '{v: '{32'h3F800000, 32'h30800000, 32'h00000000, 32'h00000000}, exp: 32'h3F800000};
    tbl[4] = '{v: '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF}, exp: 32'h7F7FFFFF};
    tbl[5] = '{v: '{32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF, 32'hFF7FFFFF}, exp: 32'hFF7FFFFF};
    tbl[6] = '{v: '{32'hC0400000, 32'h3F800000, 32'h00400000, 32'h80000000}, exp: 32'hC0000000};

    idle(2);
    chk("rst odata", odata, 32'h0);
    chk("rst vld", 32'(out_valid), 32'(0));
    chk("rst cnt", 32'(elem_cnt), 32'(0));
    reset = 1'b0;
    idle(1);

    for (int t = 0; t < 7; t++) run(tbl[t].v, 0, tbl[t].exp, $sformatf("tbl%0d", t));

    // Gapped run
    rv = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run(rv, 2, 32'h40800000, "gapped");

    // Back-to-back runs: pulses land on the 4th and 8th element only
    for (int i = 0; i < 8; i++) begin
      push(32'h40000000);
      chk("b2b vld", 32'(out_valid), 32'(i % 4 == 3));
      if (i % 4 == 3) chk("b2b odata", odata, 32'h41000000);
    end
    idle(1);

    // Reset mid-run, with a simultaneous element that must be dropped
    push(32'h41200000);
    push(32'h41200000);
    p0 = pulses;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h3F800000;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("midrst cnt", 32'(elem_cnt), 32'(0));
    chk("midrst odata", odata, 32'h0);
    chk("midrst vld", 32'(out_valid), 32'(0));
    rv = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    run(rv, 0, 32'h40800000, "post_rst");
    chk("midrst pulses", 32'(pulses - p0), 32'(1));

    // Randomised runs against the reference model
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) rv[i] = rnd_fp();
      racc = (rv[0][30:23] == 0) ? 32'h0 : rv[0];
      for (int i = 1; i < 4; i++) racc = m_add(racc, rv[i]);
      run(rv, $urandom_range(0, 2), racc, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
